// File: rtl/cv32e40p_pkg.sv
// Shared IF-stage definitions: fetch sequencer states and fetch geometry.
package cv32e40p_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        FLUSH,
        RETRY,
        FAULT
    } if_seq_state_e;

    localparam int unsigned IF_WORD_BYTES = 4;
    localparam int unsigned IF_ADDR_W     = 32;
    localparam int unsigned IF_CNT_W      = 3;

    function automatic logic [IF_ADDR_W-1:0] if_word_align(input logic [IF_ADDR_W-1:0] addr);
        return {addr[IF_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/cv32e40p_if_fetch_sequencer_if.sv
// Instruction bus request/response channel between the fetch sequencer and the bus.
interface cv32e40p_if_fetch_sequencer_if;
    import cv32e40p_pkg::*;

    logic                 fetch_req_o;
    logic [IF_ADDR_W-1:0] fetch_addr_o;
    logic                 fetch_gnt_i;
    logic                 fetch_rvalid_i;
    logic                 fetch_err_i;

    modport master (
        output fetch_req_o,
        output fetch_addr_o,
        input  fetch_gnt_i,
        input  fetch_rvalid_i,
        input  fetch_err_i
    );

    modport slave (
        input  fetch_req_o,
        input  fetch_addr_o,
        output fetch_gnt_i,
        output fetch_rvalid_i,
        output fetch_err_i
    );

endinterface

// File: rtl/cv32e40p_if_outstanding_cnt.sv
// Tracks in-flight bus transactions and how many of them must still be dropped.
module cv32e40p_if_outstanding_cnt
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    input  logic                dec,
    input  logic                discard_load,
    output logic [IF_CNT_W-1:0] outstanding,
    output logic [IF_CNT_W-1:0] outstanding_next,
    output logic [IF_CNT_W-1:0] discard,
    output logic [IF_CNT_W-1:0] discard_next
);

    localparam logic [IF_CNT_W-1:0] MaxCnt = IF_CNT_W'(MAX_OUTSTANDING);
    localparam logic [IF_CNT_W-1:0] One    = IF_CNT_W'(1);

    logic [IF_CNT_W-1:0] cnt_q, cnt_d;
    logic [IF_CNT_W-1:0] disc_q, disc_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + One;
        end else if (!inc && dec) begin
            cnt_d = cnt_q - One;
        end
    end

    // A load captures the count after this cycle's update, so a response
    // arriving in the load cycle is already accounted for.
    always_comb begin
        disc_d = disc_q;
        if (discard_load) begin
            disc_d = cnt_d;
        end else if (dec && disc_q != '0) begin
            disc_d = disc_q - One;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            disc_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            disc_q <= disc_d;
        end
    end

    assign outstanding      = cnt_q;
    assign outstanding_next = cnt_d;
    assign discard          = disc_q;
    assign discard_next     = disc_d;

    a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= MaxCnt);
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rst_n) dec |-> cnt_q != '0);

endmodule

// File: rtl/cv32e40p_if_fetch_sequencer.sv
// IF-stage fetch sequencer: boot, word fetch with credit flow control, redirect flush,
// bus-error retry and fault reporting toward the IF-ID pipeline registers.
module cv32e40p_if_fetch_sequencer
    import cv32e40p_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned RETRY_MAX       = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fetch_enable_i,
    input  logic [IF_ADDR_W-1:0]          boot_addr_i,
    input  logic                          redirect_i,
    input  logic [IF_ADDR_W-1:0]          redirect_addr_i,
    input  logic                          halt_i,
    input  logic [3:0]                    fifo_free_i,
    cv32e40p_if_fetch_sequencer_if.master bus,
    output logic                          fetch_valid_o,
    output logic                          halt_if_o,
    output logic                          clear_instr_valid_o,
    output logic                          fetch_failed_o,
    input  logic                          fault_ack_i,
    output logic                          busy_o
);

    localparam logic [IF_CNT_W-1:0] MaxOut   = IF_CNT_W'(MAX_OUTSTANDING);
    localparam logic [1:0]          RetryMax = 2'(RETRY_MAX);

    if_seq_state_e        state_q;
    logic [IF_ADDR_W-1:0] next_addr_q;
    logic [1:0]           retry_cnt_q;
    logic                 clear_q;
    logic                 failed_q;

    logic [IF_CNT_W-1:0]  outstanding;
    logic [IF_CNT_W-1:0]  outstanding_next;
    logic [IF_CNT_W-1:0]  discard;
    logic [IF_CNT_W-1:0]  discard_next;

    logic                 in_fetch;
    logic                 fetch_req;
    logic                 issued;
    logic                 rsp_ok;
    logic                 rsp_err;
    logic                 redirect_take;
    logic                 retry_ok;
    logic                 discard_load;
    logic [IF_ADDR_W-1:0] err_addr;

    assign in_fetch      = (state_q == FETCH);
    assign redirect_take = redirect_i && (state_q != IDLE) && (state_q != FAULT);
    assign rsp_ok        = bus.fetch_rvalid_i && !bus.fetch_err_i;
    assign rsp_err       = bus.fetch_rvalid_i && bus.fetch_err_i;
    assign retry_ok      = (retry_cnt_q < RetryMax);

    assign fetch_req = in_fetch && fetch_enable_i && !redirect_i && !halt_i &&
                       (outstanding < MaxOut) && ({1'b0, outstanding} < fifo_free_i);
    assign issued    = fetch_req && bus.fetch_gnt_i;

    // Responses return in order, so the failing word is the oldest one in flight.
    assign err_addr = next_addr_q - 32'(outstanding) * IF_WORD_BYTES;

    assign discard_load = redirect_take || (in_fetch && rsp_err && !redirect_i && retry_ok);

    cv32e40p_if_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstanding_cnt (
        .clk              (clk),
        .rst_n            (rst_n),
        .inc              (issued),
        .dec              (bus.fetch_rvalid_i),
        .discard_load     (discard_load),
        .outstanding      (outstanding),
        .outstanding_next (outstanding_next),
        .discard          (discard),
        .discard_next     (discard_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_addr_q <= '0;
            retry_cnt_q <= '0;
            clear_q     <= 1'b0;
            failed_q    <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            if (redirect_take) begin
                next_addr_q <= redirect_addr_i;
                retry_cnt_q <= '0;
                clear_q     <= 1'b1;
                state_q     <= (outstanding_next != '0) ? FLUSH : FETCH;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fetch_enable_i) begin
                            next_addr_q <= if_word_align(boot_addr_i);
                            retry_cnt_q <= '0;
                            state_q     <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (rsp_err) begin
                            if (retry_ok) begin
                                retry_cnt_q <= retry_cnt_q + 2'd1;
                                next_addr_q <= err_addr;
                                state_q     <= RETRY;
                            end else begin
                                failed_q <= 1'b1;
                                clear_q  <= 1'b1;
                                state_q  <= FAULT;
                            end
                        end else begin
                            if (issued) begin
                                next_addr_q <= next_addr_q + 32'(IF_WORD_BYTES);
                            end
                            if (rsp_ok) begin
                                retry_cnt_q <= '0;
                            end
                            if (!fetch_enable_i && outstanding_next == '0) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                    FLUSH, RETRY: begin
                        if (discard_next == '0) begin
                            state_q <= FETCH;
                        end
                    end
                    FAULT: begin
                        if (fault_ack_i && outstanding == '0) begin
                            failed_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.fetch_req_o  = fetch_req;
    assign bus.fetch_addr_o = next_addr_q;

    assign fetch_valid_o       = in_fetch && rsp_ok && !redirect_i && (discard == '0);
    assign halt_if_o           = halt_i || !in_fetch || (discard != '0);
    assign clear_instr_valid_o = clear_q;
    assign fetch_failed_o      = failed_q;
    assign busy_o              = (outstanding != '0) || (state_q != IDLE);

    a_no_valid_in_discard: assert property (@(posedge clk) disable iff (!rst_n)
        !(fetch_valid_o && discard != '0));
    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.fetch_req_o && !bus.fetch_gnt_i |=> !bus.fetch_req_o || $stable(bus.fetch_addr_o));

endmodule
